// File: rtl/parity_frame_rx.sv
// parity_frame_rx
//   Receiver/checker for even-parity framed serial streams. Each frame is one
//   start bit (0), DATA_W data bits LSB first, one parity bit and one stop
//   bit (1). The line is sampled only on clk edges where bit_valid is high.
//
//   Parameters:
//     DATA_W      data bits per frame, 1..16
//
//   Ports:
//     clk         system clock, rising edge
//     rst         asynchronous active-high reset
//     bit_in      serial line (idle level 1)
//     bit_valid   sample qualifier for bit_in
//     data_out    last received data word
//     data_valid  one-cycle pulse when a frame completes
//     parity_err  last completed frame had a parity mismatch
//     frame_err   last completed frame had a stop bit of 0
//     busy        frame in progress
//     err_count   (only with PARITY_RX_ERR_CNT_EN) saturating count of
//                 completed frames that had any error
//
//   Optional build macro: PARITY_RX_ERR_CNT_EN adds the err_count output.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   S_IDLE   | line idle, waiting for a valid 0 (start bit)
//   S_DATA   | collecting DATA_W data bits into shreg
//   S_PARITY | sampling the parity bit, latching the mismatch flag
//   S_STOP   | sampling the stop bit, publishing word and status

module parity_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_RX_ERR_CNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  count;
  logic              run_par;
  logic              perr;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      count      <= '0;
      run_par    <= 1'b0;
      perr       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PARITY_RX_ERR_CNT_EN
      err_count  <= 8'd0;
`endif
    end else begin
      // data_valid is a pulse: cleared on every edge unless re-set below.
      data_valid <= 1'b0;
      if (bit_valid) begin
        case (state)
          S_IDLE: begin
            if (!bit_in) begin
              shreg   <= '0;
              count   <= '0;
              run_par <= 1'b0;
              state   <= S_DATA;
            end
          end
          S_DATA: begin
            shreg[count] <= bit_in;
            run_par      <= run_par ^ bit_in;
            if (count == LAST_IDX) begin
              count <= '0;
              state <= S_PARITY;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          S_PARITY: begin
            // Even parity: data ones plus parity bit must be even.
            perr  <= run_par ^ bit_in;
            state <= S_STOP;
          end
          S_STOP: begin
            data_out   <= shreg;
            parity_err <= perr;
            frame_err  <= ~bit_in;
            data_valid <= 1'b1;
`ifdef PARITY_RX_ERR_CNT_EN
            // One increment per errored frame regardless of how many flags.
            if ((perr || !bit_in) && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
`endif
            // A 0 stop bit is consumed here; only the next 0 sampled in
            // S_IDLE starts a frame.
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
`ifdef PARITY_RX_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];

  parity_frame_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef PARITY_RX_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every data_valid pulse must match the oldest
  // outstanding expected frame.
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got data_valid=1 data_out=%h, required no pulse", data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (data_out !== e.data) begin
          failures++;
          $display("FAIL sb_data: got %h, required %h", data_out, e.data);
        end
        checks++;
        if (parity_err !== e.perr) begin
          failures++;
          $display("FAIL sb_parity_err: got %b, required %b (data %h)", parity_err, e.perr, e.data);
        end
        checks++;
        if (frame_err !== e.ferr) begin
          failures++;
          $display("FAIL sb_frame_err: got %b, required %b (data %h)", frame_err, e.ferr, e.data);
        end
      end
    end
  end

  // Called at a negedge; drives one valid bit, then gap invalid cycles.
  task automatic drive_bit(input logic b, input int gap, input bit chk, input logic exp_busy);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    if (chk) begin
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy_bit: got %b, required %b", busy, exp_busy);
      end
    end
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (chk) begin
        checks++;
        if (busy !== exp_busy) begin
          failures++;
          $display("FAIL busy_gap: got %b, required %b", busy, exp_busy);
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int gap, input bit chk);
    exp_t e;
    e.data = data;
    e.perr = (^data) ^ par;
    e.ferr = ~stop;
    sb.push_back(e);
    drive_bit(1'b0, gap, chk, 1'b1);
    for (int i = 0; i < 8; i++) drive_bit(data[i], gap, chk, 1'b1);
    drive_bit(par, gap, chk, 1'b1);
    drive_bit(stop, gap, chk, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d frames outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_in = 1'b1; bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got data_out=%h dv=%b pe=%b fe=%b busy=%b, required all 0",
               data_out, data_valid, parity_err, frame_err, busy);
    end
    rst = 1'b0;
    // Idle-level valid ones must be ignored.
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 0, 1'b1, 1'b0);
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL idle_ones: got %0d pulses, required 0", pulses);
    end
  endtask

  task automatic test_clean_frame();
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1);
    wait_drain();
  endtask

  task automatic test_parity_error();
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    wait_drain();
    repeat (5) @(negedge clk);
    checks++;
    if (parity_err !== 1'b1 || data_out !== 8'hA5 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL status_hold: got pe=%b data=%h dv=%b, required pe=1 data=a5 dv=0",
               parity_err, data_out, data_valid);
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
    wait_drain();
  endtask

  task automatic test_gapped();
    int p0;
    p0 = pulses;
    send_frame(8'h01, 1'b1, 1'b1, 3, 1'b1);
    wait_drain();
    checks++;
    if (pulses - p0 != 1) begin
      failures++;
      $display("FAIL gapped_pulses: got %0d, required 1", pulses - p0);
    end
  endtask

  task automatic test_abort();
    int p0;
    p0 = pulses;
    drive_bit(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || data_out !== 8'h00 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: got busy=%b data=%h pe=%b fe=%b, required all 0",
               busy, data_out, parity_err, frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (pulses != p0) begin
      failures++;
      $display("FAIL abort_pulse: got %0d pulses, required 0", pulses - p0);
    end
    send_frame(8'hFF, 1'b0, 1'b1, 0, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      logic       p;
      logic       s;
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s, (n % 3 == 0) ? int'($urandom_range(0, 2)) : 0, 1'b0);
    end
    wait_drain();
  endtask

`ifdef PARITY_RX_ERR_CNT_EN
  task automatic test_err_count();
    apply_reset();
    send_frame(8'h11, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1, 0, 1'b0);
    wait_drain();
    checks++;
    if (err_count !== 8'd3) begin
      failures++;
      $display("FAIL err_count_3: got %0d, required 3", err_count);
    end
    apply_reset();
    for (int n = 0; n < 300; n++) send_frame(8'h5A, 1'b1, 1'b1, 0, 1'b0);
    wait_drain();
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL err_count_sat: got %0d, required 255", err_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; bit_in = 1'b1; bit_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_frame();
    test_parity_error();
    test_frame_error();
    test_gapped();
    test_abort();
    test_back_to_back();
`ifdef PARITY_RX_ERR_CNT_EN
    test_err_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
